// File: rtl/comparator_qualifier.sv
// ---------------------------------------------------------------------------
// comparator_qualifier
//
// Digital back end for the analog comparator macro. The raw, asynchronous
// comparator output is brought into the wb_clk_i domain through a flop chain.
// A consecutive-sample glitch filter then turns it into a clean level. The
// block also produces single-cycle rise/fall pulses, saturating event
// counters, sticky event flags and a maskable interrupt.
//
// Parameters
//   SYNC_STAGES  synchroniser depth on vout_i (>= 2)
//   FILT_W       width of filt_len_i and of the internal run counter
//   CNT_W        width of the rise/fall event counters
//
// Ports
//   wb_clk_i     clock, all state on its rising edge
//   wb_rst_i     asynchronous active-high reset
//   vout_i       raw comparator output (asynchronous)
//   en_i         qualifier enable
//   filt_len_i   consecutive differing samples needed to toggle (0 acts as 1)
//   clr_i        one-cycle clear of counters, flags and overflow
//   irq_mask_i   [0] rise interrupt enable, [1] fall interrupt enable
//   vout_sync_o  last synchroniser stage
//   level_o      filtered comparator level
//   rise_o       one-cycle pulse on a 0->1 change of level_o
//   fall_o       one-cycle pulse on a 1->0 change of level_o
//   rise_cnt_o   saturating rise event count
//   fall_cnt_o   saturating fall event count
//   cnt_ovf_o    sticky: an increment was attempted at all-ones
//   flags_o      sticky event flags, [0] rise, [1] fall
//   irq_o        OR of the flags enabled by irq_mask_i
// ---------------------------------------------------------------------------
module comparator_qualifier #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8,
    parameter int CNT_W       = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              vout_i,
    input  logic              en_i,
    input  logic [FILT_W-1:0] filt_len_i,
    input  logic              clr_i,
    input  logic [1:0]        irq_mask_i,
    output logic              vout_sync_o,
    output logic              level_o,
    output logic              rise_o,
    output logic              fall_o,
    output logic [CNT_W-1:0]  rise_cnt_o,
    output logic [CNT_W-1:0]  fall_cnt_o,
    output logic              cnt_ovf_o,
    output logic [1:0]        flags_o,
    output logic              irq_o
);

    // Qualifier states
    localparam logic [1:0] ST_OFF = 2'd0;
    localparam logic [1:0] ST_ARM = 2'd1;
    localparam logic [1:0] ST_RUN = 2'd2;

    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [FILT_W:0]   LEN_ONE = {{FILT_W{1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_chain;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              level;
    logic              level_next;
    logic [FILT_W-1:0] run;
    logic [FILT_W-1:0] run_next;
    logic              rise_ev;
    logic              fall_ev;
    logic              rise_q;
    logic              fall_q;

    logic [FILT_W:0]   run_inc;
    logic [FILT_W:0]   len_eff;

    logic [CNT_W-1:0]  rise_cnt;
    logic [CNT_W-1:0]  fall_cnt;
    logic              cnt_ovf;
    logic [1:0]        flags;

    // -----------------------------------------------------------------------
    // Synchroniser: free-running, independent of the enable, so that the
    // sampled value is already settled when the qualifier is armed.
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], vout_i};
        end
    end

    assign vout_sync_o = sync_chain[SYNC_STAGES-1];

    // One extra bit keeps run+1 from wrapping when compared against the
    // filter length. A programmed length of zero behaves like one.
    assign run_inc = {1'b0, run} + LEN_ONE;
    assign len_eff = (filt_len_i == '0) ? LEN_ONE : {1'b0, filt_len_i};

    // -----------------------------------------------------------------------
    // Qualifier next-state logic.
    // ARM loads the current synchronised value as the starting level so that
    // enabling never produces a spurious event. Leaving the enabled states
    // discards any partially accumulated run.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        level_next = level;
        run_next   = run;
        rise_ev    = 1'b0;
        fall_ev    = 1'b0;

        case (state)
            ST_OFF: begin
                level_next = 1'b0;
                run_next   = '0;
                if (en_i) begin
                    state_next = ST_ARM;
                end
            end

            ST_ARM: begin
                run_next = '0;
                if (!en_i) begin
                    state_next = ST_OFF;
                    level_next = 1'b0;
                end else begin
                    state_next = ST_RUN;
                    level_next = vout_sync_o;
                end
            end

            ST_RUN: begin
                if (!en_i) begin
                    state_next = ST_OFF;
                    level_next = 1'b0;
                    run_next   = '0;
                end else if (vout_sync_o != level) begin
                    // Comparing against the live length lets a shortened
                    // length take effect on the very next differing sample.
                    if (run_inc >= len_eff) begin
                        level_next = ~level;
                        run_next   = '0;
                        rise_ev    = ~level;
                        fall_ev    = level;
                    end else begin
                        run_next = run_inc[FILT_W-1:0];
                    end
                end else begin
                    run_next = '0;
                end
            end

            default: begin
                state_next = ST_OFF;
                level_next = 1'b0;
                run_next   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Qualifier state, filtered level and registered event pulses. The
    // pulses share the edge on which the level toggles, so they are visible
    // in the same cycle as the new level.
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state  <= ST_OFF;
            level  <= 1'b0;
            run    <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            state  <= state_next;
            level  <= level_next;
            run    <= run_next;
            rise_q <= rise_ev;
            fall_q <= fall_ev;
        end
    end

    // -----------------------------------------------------------------------
    // Event counters, overflow and sticky flags. On a clear the event of the
    // same edge is still recorded: the counter restarts at one and the flag
    // is set, so no event is lost to a clear.
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rise_cnt <= '0;
            fall_cnt <= '0;
            cnt_ovf  <= 1'b0;
            flags    <= 2'b00;
        end else if (clr_i) begin
            rise_cnt <= rise_ev ? CNT_ONE : '0;
            fall_cnt <= fall_ev ? CNT_ONE : '0;
            cnt_ovf  <= 1'b0;
            flags    <= {fall_ev, rise_ev};
        end else begin
            if (rise_ev) begin
                if (rise_cnt == CNT_MAX) begin
                    cnt_ovf <= 1'b1;
                end else begin
                    rise_cnt <= rise_cnt + CNT_ONE;
                end
                flags[0] <= 1'b1;
            end
            if (fall_ev) begin
                if (fall_cnt == CNT_MAX) begin
                    cnt_ovf <= 1'b1;
                end else begin
                    fall_cnt <= fall_cnt + CNT_ONE;
                end
                flags[1] <= 1'b1;
            end
        end
    end

    // The interrupt depends only on the registered flags and the mask. It has
    // no combinational path from the comparator input.
    assign irq_o = |(flags & irq_mask_i);

    assign level_o    = level;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign rise_cnt_o = rise_cnt;
    assign fall_cnt_o = fall_cnt;
    assign cnt_ovf_o  = cnt_ovf;
    assign flags_o    = flags;

endmodule

// File: tb/tb_comparator_qualifier.sv
// ---------------------------------------------------------------------------
// tb_comparator_qualifier
//
// Scoreboard bench for comparator_qualifier (SYNC_STAGES=2, FILT_W=8,
// CNT_W=4). The stimulus side applies inputs once per cycle, advances a
// behavioural model and pushes the expected outputs. A monitor pops each
// entry on the falling edge and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_comparator_qualifier;

    localparam int SYNC_STAGES = 2;
    localparam int FILT_W      = 8;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              vout;
    logic              en;
    logic [FILT_W-1:0] filt_len;
    logic              clr;
    logic [1:0]        irq_mask;
    logic              vout_sync;
    logic              level;
    logic              rise;
    logic              fall;
    logic [CNT_W-1:0]  rise_cnt;
    logic [CNT_W-1:0]  fall_cnt;
    logic              cnt_ovf;
    logic [1:0]        flags;
    logic              irq;

    typedef struct {
        bit       vs;
        bit       lvl;
        bit       r;
        bit       f;
        int       rc;
        int       fc;
        bit       ovf;
        bit [1:0] fl;
        bit       irq;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit [1:0] m_sync;
    int       m_en_age;
    bit       m_level;
    int       m_run;
    bit       m_rise;
    bit       m_fall;
    int       m_rc;
    int       m_fc;
    bit       m_ovf;
    bit [1:0] m_flags;

    comparator_qualifier #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_W      (FILT_W),
        .CNT_W       (CNT_W)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .vout_i      (vout),
        .en_i        (en),
        .filt_len_i  (filt_len),
        .clr_i       (clr),
        .irq_mask_i  (irq_mask),
        .vout_sync_o (vout_sync),
        .level_o     (level),
        .rise_o      (rise),
        .fall_o      (fall),
        .rise_cnt_o  (rise_cnt),
        .fall_cnt_o  (fall_cnt),
        .cnt_ovf_o   (cnt_ovf),
        .flags_o     (flags),
        .irq_o       (irq)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point feeding the pass/fail counters
    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_sync   = 2'b00;
        m_en_age = 0;
        m_level  = 1'b0;
        m_run    = 0;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        m_rc     = 0;
        m_fc     = 0;
        m_ovf    = 1'b0;
        m_flags  = 2'b00;
    endtask

    // Advance the model over one rising edge using the inputs the DUT just
    // sampled. The qualifier is described by how long en has been high:
    // first enabled edge does nothing, second adopts the synchronised value,
    // after that the run-length filter applies.
    task automatic modelEdge();
        bit seen;
        int need;
        seen   = m_sync[1];
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (rst) begin
            modelReset();
            return;
        end
        m_sync = {m_sync[0], vout};
        if (!en) begin
            m_en_age = 0;
            m_level  = 1'b0;
            m_run    = 0;
        end else if (m_en_age == 0) begin
            m_en_age = 1;
        end else if (m_en_age == 1) begin
            m_en_age = 2;
            m_level  = seen;
            m_run    = 0;
        end else begin
            need = (filt_len == 0) ? 1 : int'(filt_len);
            if (seen != m_level) begin
                if (m_run + 1 >= need) begin
                    m_level = !m_level;
                    m_run   = 0;
                    if (m_level) m_rise = 1'b1;
                    else         m_fall = 1'b1;
                end else begin
                    m_run = m_run + 1;
                end
            end else begin
                m_run = 0;
            end
        end
        if (clr) begin
            m_rc    = m_rise ? 1 : 0;
            m_fc    = m_fall ? 1 : 0;
            m_ovf   = 1'b0;
            m_flags = {m_fall, m_rise};
        end else begin
            if (m_rise) begin
                if (m_rc == CNT_MAX) m_ovf = 1'b1;
                else                 m_rc  = m_rc + 1;
                m_flags[0] = 1'b1;
            end
            if (m_fall) begin
                if (m_fc == CNT_MAX) m_ovf = 1'b1;
                else                 m_fc  = m_fc + 1;
                m_flags[1] = 1'b1;
            end
        end
    endtask

    // One cycle: settle the model for the edge just taken, apply the next
    // inputs (a reset takes effect at once) and queue the expected outputs.
    task automatic applyStimulus(input bit r, input bit e, input bit v,
                                 input logic [FILT_W-1:0] l, input bit c,
                                 input logic [1:0] m);
        exp_t x;
        @(posedge clk);
        #1;
        modelEdge();
        rst      = r;
        en       = e;
        vout     = v;
        filt_len = l;
        clr      = c;
        irq_mask = m;
        if (r) modelReset();
        x.vs  = m_sync[1];
        x.lvl = m_level;
        x.r   = m_rise;
        x.f   = m_fall;
        x.rc  = m_rc;
        x.fc  = m_fc;
        x.ovf = m_ovf;
        x.fl  = m_flags;
        x.irq = |(m_flags & m);
        sb.push_back(x);
    endtask

    // Monitor: compares the DUT against the oldest queued expectation
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checkOutput("vout_sync", int'(vout_sync), int'(x.vs));
                checkOutput("level",     int'(level),     int'(x.lvl));
                checkOutput("rise",      int'(rise),      int'(x.r));
                checkOutput("fall",      int'(fall),      int'(x.f));
                checkOutput("rise_cnt",  int'(rise_cnt),  x.rc);
                checkOutput("fall_cnt",  int'(fall_cnt),  x.fc);
                checkOutput("cnt_ovf",   int'(cnt_ovf),   int'(x.ovf));
                checkOutput("flags",     int'(flags),     int'(x.fl));
                checkOutput("irq",       int'(irq),       int'(x.irq));
            end
        end
    end

    initial begin
        bit       v;
        int       hold;
        bit       e;
        logic [FILT_W-1:0] l;
        logic [1:0] m;

        rst      = 1'b1;
        en       = 1'b0;
        vout     = 1'b0;
        filt_len = 8'd5;
        clr      = 1'b0;
        irq_mask = 2'b00;
        modelReset();

        // Reset held, then reset asserted in the middle of a filter run
        repeat (3) applyStimulus(1, 0, 0, 8'd5, 0, 2'b11);
        repeat (4) applyStimulus(0, 1, 0, 8'd5, 0, 2'b11);
        applyStimulus(0, 1, 1, 8'd5, 0, 2'b11);
        repeat (4) applyStimulus(0, 1, 1, 8'd5, 0, 2'b11);
        repeat (2) applyStimulus(1, 1, 1, 8'd5, 0, 2'b11);
        repeat (6) applyStimulus(0, 1, 1, 8'd5, 0, 2'b11);

        // Latency with L=4 from a clean low level
        repeat (2) applyStimulus(0, 0, 0, 8'd4, 0, 2'b11);
        repeat (6) applyStimulus(0, 1, 0, 8'd4, 0, 2'b11);
        repeat (8) applyStimulus(0, 1, 1, 8'd4, 0, 2'b11);

        // Glitches: rejected with L=4, followed with L=0
        applyStimulus(0, 1, 0, 8'd4, 1, 2'b11);
        repeat (6) applyStimulus(0, 1, 0, 8'd4, 0, 2'b11);
        repeat (3) applyStimulus(0, 1, 1, 8'd4, 0, 2'b11);
        repeat (8) applyStimulus(0, 1, 0, 8'd4, 0, 2'b11);
        applyStimulus(0, 1, 1, 8'd0, 1, 2'b11);
        repeat (6) applyStimulus(0, 1, 0, 8'd0, 0, 2'b11);

        // Saturation: 17 rises and 17 falls, then clear, then a clear on
        // the same edge as a fall event
        applyStimulus(0, 1, 0, 8'd1, 1, 2'b11);
        for (int i = 0; i < 34; i++) applyStimulus(0, 1, ((i % 2) == 0), 8'd1, 0, 2'b11);
        repeat (4) applyStimulus(0, 1, 0, 8'd1, 0, 2'b11);
        applyStimulus(0, 1, 0, 8'd1, 1, 2'b11);
        repeat (4) applyStimulus(0, 1, 1, 8'd1, 0, 2'b11);
        repeat (2) applyStimulus(0, 1, 0, 8'd1, 0, 2'b11);
        applyStimulus(0, 1, 0, 8'd1, 1, 2'b11);
        repeat (3) applyStimulus(0, 1, 0, 8'd1, 0, 2'b11);

        // Interrupt mask: only fall enabled
        applyStimulus(0, 1, 0, 8'd2, 1, 2'b10);
        repeat (5) applyStimulus(0, 1, 1, 8'd2, 0, 2'b10);
        repeat (5) applyStimulus(0, 1, 0, 8'd2, 0, 2'b10);

        // Enable dropped mid-run, then re-armed with the input high
        applyStimulus(0, 1, 1, 8'd6, 0, 2'b11);
        repeat (3) applyStimulus(0, 1, 1, 8'd6, 0, 2'b11);
        repeat (3) applyStimulus(0, 0, 1, 8'd6, 0, 2'b11);
        repeat (6) applyStimulus(0, 1, 1, 8'd6, 0, 2'b11);

        // Randomised traffic
        v    = 1'b0;
        hold = 0;
        l    = 8'd3;
        m    = 2'b11;
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0) begin
                v    = 1'($urandom_range(1, 0));
                hold = int'($urandom_range(8, 1));
            end
            hold = hold - 1;
            if ($urandom_range(49, 0) == 0) l = FILT_W'($urandom_range(6, 0));
            if ($urandom_range(63, 0) == 0) m = 2'($urandom_range(3, 0));
            e = ($urandom_range(39, 0) != 0);
            applyStimulus(($urandom_range(299, 0) == 0), e, v, l,
                          ($urandom_range(29, 0) == 0), m);
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("scoreboard_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
